// File: rtl/iter_mul_if.sv
// ---------------------------------------------------------------------------
// iter_mul_if
// Operand/result handshake bundle between the execute stage and the
// sequential shift-add multiplier.
//   in_valid / in_ready   : operand pair handshake (op_a, op_x, apx)
//   out_valid / out_ready : result handshake (result)
//   busy                  : unit is working or holding a result
// Modports: master = issuing/writeback side, slave = multiplier.
// ---------------------------------------------------------------------------
interface iter_mul_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_x;
    logic            apx;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            busy;

    modport master (
        output in_valid, op_a, op_x, apx, out_ready,
        input  in_ready, out_valid, result, busy
    );

    modport slave (
        input  in_valid, op_a, op_x, apx, out_ready,
        output in_ready, out_valid, result, busy
    );
endinterface

// File: rtl/iter_mul_unit.sv
// ---------------------------------------------------------------------------
// iter_mul_unit
// Sequential shift-add multiplier beside the single-cycle ALU. Accepts one
// operand pair, iterates one multiplier bit per clock and returns the low
// XLEN bits of the product through a valid/ready handshake.
//
// Ports:
//   clk    : clock, rising edge
//   reset  : synchronous, active-high
//   mul    : iter_mul_if.slave (in_valid/in_ready, op_a, op_x, apx,
//            out_valid/out_ready, result, busy)
//
// Build option:
//   MUL_APX_EN : when defined, apx=1 at accept skips the low APX_TRUNC
//                multiplier bits (latency XLEN-APX_TRUNC). When undefined,
//                apx is ignored and every operation is exact.
// ---------------------------------------------------------------------------
module iter_mul_unit #(
    parameter int XLEN      = 32,
    parameter int APX_TRUNC = 8
) (
    input  logic          clk,
    input  logic          reset,
    iter_mul_if.slave     mul
);

    localparam int CNT_W = $clog2(XLEN + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    logic [XLEN-1:0]   acc;
    logic [XLEN-1:0]   mcand;
    logic [XLEN-1:0]   mplier;
    logic [CNT_W-1:0]  cnt;
    logic              in_ready_q;
    logic              out_valid_q;
    logic              busy_q;

    // Modular accumulate: overflow beyond XLEN bits is dropped on purpose.
    function automatic logic [XLEN-1:0] add_wrap(input logic [XLEN-1:0] a,
                                                 input logic [XLEN-1:0] b);
        return a + b;
    endfunction

`ifndef MUL_APX_EN
    // apx is part of the bundle but has no function in the exact-only build.
    logic unused_apx;
    assign unused_apx = mul.apx;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            acc         <= '0;
            mcand       <= '0;
            mplier      <= '0;
            cnt         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (mul.in_valid) begin
                        acc        <= '0;
`ifdef MUL_APX_EN
                        if (mul.apx) begin
                            // Pre-shift so the low multiplier bits are never visited.
                            mcand  <= mul.op_a << APX_TRUNC;
                            mplier <= mul.op_x >> APX_TRUNC;
                            cnt    <= CNT_W'(XLEN - APX_TRUNC);
                        end else begin
                            mcand  <= mul.op_a;
                            mplier <= mul.op_x;
                            cnt    <= CNT_W'(XLEN);
                        end
`else
                        mcand      <= mul.op_a;
                        mplier     <= mul.op_x;
                        cnt        <= CNT_W'(XLEN);
`endif
                        state      <= RUN;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end

                RUN: begin
                    if (mplier[0]) begin
                        acc <= add_wrap(acc, mcand);
                    end
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt - CNT_W'(1);
                    // Last iteration happens on this edge; result is final after it.
                    if (cnt == CNT_W'(1)) begin
                        state       <= DONE;
                        out_valid_q <= 1'b1;
                    end
                end

                DONE: begin
                    if (mul.out_ready) begin
                        state       <= IDLE;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end

                default: begin
                    state       <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign mul.in_ready  = in_ready_q;
    assign mul.out_valid = out_valid_q;
    assign mul.busy      = busy_q;
    assign mul.result    = acc;

endmodule

// File: doc/iter_mul_unit.md
# iter_mul_unit

Sequential shift-add multiplier in the execute stage, beside the single-cycle ALU. It takes the same operand pair the ALU receives (rs1 value and the ALU-MUX-selected second operand) whenever the decoded operation is a multiply. It returns the low XLEN bits of the product to the writeback mux through a valid/ready handshake. While it is busy, the pipeline control stalls instruction issue.

## Interface
- XLEN, 32, operand and result width
- APX_TRUNC, 8, number of low multiplier bits skipped in approximate mode (1..XLEN-1)

- clk  in  1  clock, rising edge
- reset  in  1  reset, synchronous, active-high
- in_valid  in  1  operand pair valid
- in_ready  out  1  unit can accept operands
- op_a  in  XLEN  multiplicand (rs1)
- op_x  in  XLEN  multiplier (ALU-MUX output)
- apx  in  1  request approximate multiply (used only with MUL_APX_EN)
- out_valid  out  1  result valid
- out_ready  in  1  writeback accepts result
- result  out  XLEN  low XLEN bits of product
- busy  out  1  high in RUN or DONE

## Operation
- States: IDLE, RUN, DONE. Reset enters IDLE.
- **IDLE:**
  - in_ready=1.
  - The handshake fires when in_valid is high at a rising edge.
  - On that edge: capture mcand=op_a and mplier=op_x, clear acc to 0, load the iteration counter, and go to RUN.
- **RUN:**
  - in_ready=0.
  - Each edge: if mplier[0], acc <= acc + mcand (mod 2^XLEN).
  - Then mcand <= mcand<<1, mplier <= mplier>>1, and the counter decrements.
  - When the counter reaches 0 after an update, go to DONE.
- **DONE:**
  - out_valid=1 and result=acc, both held stable until out_ready is seen high at an edge.
  - After that edge, go to IDLE.
- Arithmetic:
  - Unsigned shift-add, truncated to XLEN bits.
  - The low XLEN bits are identical for signed and unsigned operands.
  - Overflow is discarded silently.
- Inputs are sampled only at the accept edge. Changes to op_a, op_x or apx afterwards have no effect.
- in_valid during RUN or DONE is ignored; the upstream holds it.
- result is driven from acc in every state. It is meaningful only while out_valid=1.

## Timing
- Reset values: in_ready=1, out_valid=0, busy=0, result=0. Internal state: acc=0, counter=0, state=IDLE.
- Exact latency:
  - out_valid rises XLEN edges after the accept edge (32 for the default).
  - Accept at edge E0, RUN updates at E1..E32, out_valid=1 in the cycle after E32.
- Approximate latency: XLEN-APX_TRUNC edges (24 for the default).
- Throughput:
  - One operation in flight.
  - A result handshake at edge En puts in_ready=1 after En, so the next accept is at En+1 at the earliest.
  - Minimum issue interval is XLEN+2 cycles.
- Backpressure: out_ready held low keeps the unit in DONE indefinitely, with result and out_valid constant.
- Reset mid-operation:
  - Reset high at any edge abandons the operation and returns to reset values after that edge.
  - Reset has priority over in_valid and out_ready at the same edge.
- out_ready is ignored outside DONE.

## Configuration
- **MUL_APX_EN defined:**
  - If apx=1 at the accept edge, the unit loads mcand=op_a<<APX_TRUNC and mplier=op_x>>APX_TRUNC, with counter=XLEN-APX_TRUNC.
  - The partial products for the low APX_TRUNC multiplier bits are therefore omitted.
  - Result = (op_a * (op_x & ~(2^APX_TRUNC-1))) mod 2^XLEN.
  - apx=0 gives the exact multiply.
- **MUL_APX_EN undefined:**
  - The apx port exists but is ignored.
  - Every operation is exact with latency XLEN.
  - No truncation logic is synthesized.

## Test plan
- **Basic:** op_a=6, op_x=7, in_valid pulse -> out_valid 32 edges later, result=42, busy high throughout.
- **Wrap:** op_a=0xFFFFFFFF, op_x=0xFFFFFFFF -> result=0x00000001. op_a=0x80000000, op_x=2 -> result=0.
- **Backpressure:** out_ready low for 5 cycles in DONE -> result and out_valid stable. in_valid held high meanwhile -> in_ready stays 0 and there is no capture. The next accept happens one cycle after the out_ready handshake.
- **Reset mid-RUN:** reset asserted 10 edges after accept -> next cycle out_valid=0, busy=0, in_ready=1, result=0. A new op 3*5 afterwards gives 15.
- **Approximate with MUL_APX_EN:** op_a=0x100, op_x=0x1FF, apx=1 -> result=0x10000 after 24 edges. The same operands with apx=0 give 0x1FF00 after 32 edges.
- **Approximate without MUL_APX_EN:** op_a=0x100, op_x=0x1FF, apx=1 -> result=0x1FF00 after 32 edges.
